// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer and synchronous flush.
// Optional STALL_CNT_EN macro adds a saturating stall-cycle counter on stall_cnt.
module pipe_stage_reg #(
  parameter int unsigned W              = 32,
  parameter int unsigned CLEAR_ON_FLUSH = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   main_q;
  logic [W-1:0]   skid_q;
  logic           accept;
  logic           consume;

  // Handshake outputs decode registered state only, so neither side sees a combinational path.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != SKID);
  assign out_data  = main_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= FULL;
            main_q <= in_data;
          end
        end
        FULL: begin
          if (accept && consume) begin
            main_q <= in_data;
          end else if (accept) begin
            state  <= SKID;
            skid_q <= in_data;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (consume) begin
            state  <= FULL;
            main_q <= skid_q;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand-written reset/stall
// sequences and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_c, out_valid_c;
  logic [31:0] out_data_c;
  logic [15:0] stall_c;
  logic        in_ready_h, out_valid_h;
  logic [31:0] out_data_h;
  logic [1:0]  stall_h;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.W(32), .CLEAR_ON_FLUSH(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .stall_cnt(stall_c)
  );

  pipe_stage_reg #(.W(32), .CLEAR_ON_FLUSH(0), .CNT_W(2)) dut_h (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
    .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h),
    .stall_cnt(stall_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a FIFO of at most two payloads plus the last value shown on out_data.
  logic [31:0] q[$];
  logic [31:0] m_main_c, m_main_h;
  int          m_cnt_c, m_cnt_h;

  function automatic int exp_cnt(input int v);
`ifdef STALL_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_main_c = '0;
    m_main_h = '0;
    m_cnt_c  = 0;
    m_cnt_h  = 0;
  endtask

  task automatic model_step();
    bit had  = (q.size() > 0);
    bit room = (q.size() < 2);
    if (!flush && had && !out_ready) begin
      if (m_cnt_c < 65535) m_cnt_c++;
      if (m_cnt_h < 3) m_cnt_h++;
    end
    if (flush) begin
      q.delete();
      m_main_c = '0;
    end else begin
      if (had && out_ready) void'(q.pop_front());
      if (in_valid && room) q.push_back(in_data);
      if (q.size() > 0) begin
        m_main_c = q[0];
        m_main_h = q[0];
      end
    end
  endtask

  task automatic model_check();
    chk("out_valid_c", 64'(out_valid_c), 64'(q.size() > 0));
    chk("out_valid_h", 64'(out_valid_h), 64'(q.size() > 0));
    chk("in_ready_c", 64'(in_ready_c), 64'(q.size() < 2));
    chk("in_ready_h", 64'(in_ready_h), 64'(q.size() < 2));
    chk("out_data_c", 64'(out_data_c), 64'(m_main_c));
    chk("out_data_h", 64'(out_data_h), 64'(m_main_h));
    chk("stall_c", 64'(stall_c), 64'(exp_cnt(m_cnt_c)));
    chk("stall_h", 64'(stall_h), 64'(exp_cnt(m_cnt_h)));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [31:0] odc;
    logic [31:0] odh;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                              input logic ov, input logic ir, input logic [31:0] odc,
                              input logic [31:0] odh);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.odc = odc; v.odh = odh;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    // Expected outputs are those seen one edge after the row's inputs are applied.
    tbl[0]  = mk(0, 0, 32'h00, 0,  0, 1, 32'h00, 32'h00);
    tbl[1]  = mk(0, 1, 32'h11, 1,  1, 1, 32'h11, 32'h11);
    tbl[2]  = mk(0, 1, 32'h22, 1,  1, 1, 32'h22, 32'h22);
    tbl[3]  = mk(0, 1, 32'h33, 1,  1, 1, 32'h33, 32'h33);
    tbl[4]  = mk(0, 0, 32'h00, 1,  0, 1, 32'h33, 32'h33);
    tbl[5]  = mk(0, 1, 32'h0A, 0,  1, 1, 32'h0A, 32'h0A);
    tbl[6]  = mk(0, 1, 32'h0B, 0,  1, 0, 32'h0A, 32'h0A);
    tbl[7]  = mk(0, 1, 32'h0C, 0,  1, 0, 32'h0A, 32'h0A);
    tbl[8]  = mk(0, 0, 32'h00, 1,  1, 1, 32'h0B, 32'h0B);
    tbl[9]  = mk(0, 0, 32'h00, 1,  0, 1, 32'h0B, 32'h0B);
    tbl[10] = mk(0, 1, 32'h0A, 0,  1, 1, 32'h0A, 32'h0A);
    tbl[11] = mk(0, 1, 32'h0B, 0,  1, 0, 32'h0A, 32'h0A);
    tbl[12] = mk(1, 1, 32'h77, 0,  0, 1, 32'h00, 32'h0A);
    tbl[13] = mk(0, 0, 32'h00, 1,  0, 1, 32'h00, 32'h0A);
    tbl[14] = mk(0, 1, 32'h5A, 1,  1, 1, 32'h5A, 32'h5A);
    tbl[15] = mk(1, 1, 32'h66, 1,  0, 1, 32'h00, 32'h5A);
    tbl[16] = mk(0, 0, 32'h00, 1,  0, 1, 32'h00, 32'h5A);

    rst = 1'b1;
    drive(0, 0, 32'h0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid_c), 64'(0));
    chk("reset_in_ready", 64'(in_ready_c), 64'(1));
    chk("reset_out_data", 64'(out_data_c), 64'(0));

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      step();
      chk($sformatf("vec%0d_ov_c", i), 64'(out_valid_c), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_ov_h", i), 64'(out_valid_h), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_ir", i), 64'(in_ready_c), 64'(tbl[i].ir));
      chk($sformatf("vec%0d_od_c", i), 64'(out_data_c), 64'(tbl[i].odc));
      chk($sformatf("vec%0d_od_h", i), 64'(out_data_h), 64'(tbl[i].odh));
    end

    // Async reset in the middle of a cycle while holding two entries.
    drive(0, 1, 32'h0A, 0); step();
    drive(0, 1, 32'h0B, 0); step();
    chk("skid_before_rst", 64'(in_ready_c), 64'(0));
    drive(0, 0, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ov", 64'(out_valid_c), 64'(0));
    chk("async_rst_ir", 64'(in_ready_c), 64'(1));
    chk("async_rst_od_c", 64'(out_data_c), 64'(0));
    chk("async_rst_od_h", 64'(out_data_h), 64'(0));
    chk("async_rst_stall_c", 64'(stall_c), 64'(0));
    chk("async_rst_stall_h", 64'(stall_h), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0); step();
    chk("post_rst_idle", 64'(out_valid_c), 64'(0));

    // First payload after reset, then a 5-cycle stall, then emitted exactly once.
    drive(0, 1, 32'h05, 0); step();
    chk("first_ov", 64'(out_valid_c), 64'(1));
    chk("first_od", 64'(out_data_c), 64'(32'h05));
    drive(0, 0, 32'h0, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("stall%0d_h", k), 64'(stall_h), 64'(exp_cnt(k < 3 ? k : 3)));
      chk($sformatf("stall%0d_c", k), 64'(stall_c), 64'(exp_cnt(k)));
    end
    drive(0, 0, 32'h0, 1); step();
    chk("emit_once_ov", 64'(out_valid_c), 64'(0));
    step();
    chk("emit_once_ov2", 64'(out_valid_c), 64'(0));
    drive(0, 1, 32'h09, 0); step();
    drive(1, 0, 32'h0, 0); step();
    chk("flush_nocount_c", 64'(stall_c), 64'(exp_cnt(5)));
    chk("flush_nocount_h", 64'(stall_h), 64'(exp_cnt(3)));
    chk("flush_ov", 64'(out_valid_c), 64'(0));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
